// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   state_e  : responder FSM states (IDLE, BUSY, RESP)
//   CNT_W    : width of the latency countdown counter
//   clog2()  : word-index width for a given array depth
//   addr_ok(): 1 when a byte address is word-aligned and inside the array
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CNT_W = 4;

    function automatic int clog2(input int unsigned n);
        int r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Aligned (low two bits zero) and word index below depth, i.e. no
    // address bits set above the array's index field.
    function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(depth));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Bus between the MEM stage (master) and the data-memory responder (slave).
//   req_i   : request, held high by the master until ack_o
//   we_i    : 1 = store, 0 = load, sampled at acceptance
//   addr_i  : byte address, sampled at acceptance
//   wdata_i : store data, sampled at acceptance
//   rdata_o : load data, valid only while ack_o = 1
//   ack_o   : single-cycle completion pulse
//   err_o   : misaligned / out-of-range flag, valid only while ack_o = 1
//   stall_o : pipeline hold while an access is outstanding
//
// Handshake: the master raises req_i with we/addr/wdata and keeps req_i high
// until it sees ack_o. The slave accepts on the first edge where it is idle
// and req_i is high, and answers with a one-cycle ack_o LATENCY cycles later.
// Dropping req_i before ack_o aborts the access (no store, no ack). req_i
// still high in the cycle after ack_o is a new request.
interface dmem_responder_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              ack_o;
    logic              err_o;
    logic              stall_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ack_o, err_o, stall_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ack_o, err_o, stall_o
    );
endinterface

// File: rtl/dmem_latency_counter.sv
// Down-counter that times the access latency.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : force the count to zero (abort)
//   load_i       : load load_val_i (takes priority over dec_i)
//   dec_i        : decrement, saturating at zero
//   zero_o       : count is zero
//   last_o       : count is one, so this decrement reaches zero
module dmem_latency_counter
    import dmem_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o,
    output logic         last_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == W'(1));
endmodule

// File: rtl/dmem_responder.sv
// Responder side of the CPU data-memory port: accepts word loads/stores,
// models a fixed multi-cycle latency, holds the storage array, stalls the
// pipeline while an access is outstanding and flags bad addresses.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : slave side of dmem_responder_if
//   state_o      : current FSM state (debug visibility)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3,
    parameter int ADDR_W  = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dmem_responder_if.slave     bus,
    output state_e              state_o
);
    localparam int              IDX_W    = clog2(DEPTH);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              cnt_clr, cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic              mem_we;
    logic              acc_ok;
    logic [IDX_W-1:0]  word_idx;
    logic              ok_next;

    logic [31:0]       mem_q [DEPTH];

    assign acc_ok   = addr_ok(64'(addr_q), DEPTH);
    assign word_idx = addr_q[IDX_W+1:2];

    dmem_latency_counter #(.W(CNT_W)) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        ok_next  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    we_d     = bus.we_i;
                    addr_d   = bus.addr_i;
                    wdata_d  = bus.wdata_i;
                    cnt_load = 1'b1;
                    state_d  = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                // Abort wins over completion, even on the final countdown cycle.
                if (!bus.req_i) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                    // BUSY lasts LATENCY-1 cycles, so RESP is entered on the
                    // edge where the count drops from one to zero.
                    if (cnt_last || cnt_zero) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                mem_we  = we_q && acc_ok && !rst_i;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response outputs are registered on entry to RESP, using the
        // next-cycle copy of the access so LATENCY = 1 works too.
        if (state_d == RESP) begin
            ok_next = addr_ok(64'(addr_d), DEPTH);
            ack_d   = 1'b1;
            err_d   = !ok_next;
            if (ok_next && !we_d) begin
                rdata_d = mem_q[addr_d[IDX_W+1:2]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately not reset; a store commits on the RESP edge.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[word_idx] <= wdata_q;
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.rdata_o = rdata_q;
    assign bus.stall_o = ((state_q == IDLE) && bus.req_i) || (state_q == BUSY);
    assign state_o     = state_q;
endmodule
